// File: rtl/decode_imm_stage_pkg.sv
// Shared RISC-V instruction layout, opcode/funct3 constants and immediate
// format encoding for the decode-immediate stage.
package decode_imm_stage_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    localparam logic [6:0] OPCODE_LOAD      = 7'h03;
    localparam logic [6:0] OPCODE_MISC_MEM  = 7'h0F;
    localparam logic [6:0] OPCODE_OP_IMM    = 7'h13;
    localparam logic [6:0] OPCODE_AUIPC     = 7'h17;
    localparam logic [6:0] OPCODE_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPCODE_STORE     = 7'h23;
    localparam logic [6:0] OPCODE_OP        = 7'h33;
    localparam logic [6:0] OPCODE_LUI       = 7'h37;
    localparam logic [6:0] OPCODE_OP_32     = 7'h3B;
    localparam logic [6:0] OPCODE_BRANCH    = 7'h63;
    localparam logic [6:0] OPCODE_JALR      = 7'h67;
    localparam logic [6:0] OPCODE_JAL       = 7'h6F;
    localparam logic [6:0] OPCODE_SYSTEM    = 7'h73;

    localparam logic [2:0] FUNCT3_SYSTEM_PRIV   = 3'b000;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_SYSTEM_CSRRCI = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_CSRUI = 3'd6
    } imm_fmt_t;

endpackage

// File: rtl/decode_imm_stage_imm_decode.sv
// Purely combinational immediate extraction: format classification, the
// 32-bit immediate, and sign extension to the datapath width.
module imm_decode
    import decode_imm_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  instruction_t      instr_i,
    output logic [XLEN-1:0]   imm_o,
    output imm_fmt_t          fmt_o,
    output logic              illegal_o
);

    logic [31:0] raw_s;
    logic [31:0] imm32_s;

    assign raw_s = instr_i;

    // Classify the opcode and assemble the immediate in 32-bit form.
    always_comb begin
        imm32_s   = 32'd0;
        fmt_o     = IMM_NONE;
        illegal_o = 1'b0;
        if (raw_s[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (instr_i.opcode)
                OPCODE_LUI, OPCODE_AUIPC: begin
                    fmt_o   = IMM_U;
                    imm32_s = {raw_s[31:12], 12'd0};
                end
                OPCODE_JAL: begin
                    fmt_o   = IMM_J;
                    imm32_s = {{11{raw_s[31]}}, raw_s[31], raw_s[19:12],
                               raw_s[20], raw_s[30:21], 1'b0};
                end
                OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_OP_IMM_32: begin
                    fmt_o   = IMM_I;
                    imm32_s = {{20{raw_s[31]}}, raw_s[31:20]};
                end
                OPCODE_BRANCH: begin
                    fmt_o   = IMM_B;
                    imm32_s = {{19{raw_s[31]}}, raw_s[31], raw_s[7],
                               raw_s[30:25], raw_s[11:8], 1'b0};
                end
                OPCODE_STORE: begin
                    fmt_o   = IMM_S;
                    imm32_s = {{20{raw_s[31]}}, raw_s[31:25], raw_s[11:7]};
                end
                OPCODE_SYSTEM: begin
                    case (instr_i.funct3)
                        FUNCT3_SYSTEM_CSRRWI, FUNCT3_SYSTEM_CSRRSI,
                        FUNCT3_SYSTEM_CSRRCI: begin
                            fmt_o   = IMM_CSRUI;
                            imm32_s = {27'd0, instr_i.rs1};
                        end
                        default: begin
                            fmt_o   = IMM_NONE;
                            imm32_s = 32'd0;
                        end
                    endcase
                end
                OPCODE_OP, OPCODE_OP_32, OPCODE_MISC_MEM: begin
                    fmt_o   = IMM_NONE;
                    imm32_s = 32'd0;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // CSRUI is already zero-padded in bit 31, so one sign extension serves all formats.
    if (XLEN > 32) begin : g_ext
        assign imm_o = {{(XLEN-32){imm32_s[31]}}, imm32_s};
    end else begin : g_noext
        assign imm_o = imm32_s[XLEN-1:0];
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode-immediate pipeline stage: decodes on the input side and registers the
// result behind a valid/ready handshake with an optional two-entry skid buffer.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  instruction_t      instr_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [XLEN-1:0]   imm_o,
    output imm_fmt_t          imm_fmt_o,
    output logic              imm_illegal_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    instruction_t     out_instr_q, out_instr_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    imm_fmt_t         out_fmt_q, out_fmt_d;
    logic             out_ill_q, out_ill_d;
    instruction_t     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]  skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    imm_fmt_t         skid_fmt_q, skid_fmt_d;
    logic             skid_ill_q, skid_ill_d;

    logic [XLEN-1:0]  dec_imm_s;
    imm_fmt_t         dec_fmt_s;
    logic             dec_ill_s;
    logic             in_xfer_s, out_xfer_s;
    logic             load_out_in_s, load_out_skid_s, load_skid_s;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .instr_i   (instr_i),
        .imm_o     (dec_imm_s),
        .fmt_o     (dec_fmt_s),
        .illegal_o (dec_ill_s)
    );

    // Without the skid entry, ready must see the downstream ready in the same cycle.
    assign in_ready_o = (SKID_EN != 0) ? in_ready_q : (!out_valid_q || out_ready_i);
    assign in_xfer_s  = in_valid_i && in_ready_o;
    assign out_xfer_s = out_valid_q && out_ready_i;

    // Occupancy FSM: decides which register loads from where each cycle.
    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_d       = ST_ONE;
                    out_valid_d   = 1'b1;
                    load_out_in_s = 1'b1;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    load_out_in_s = 1'b1;
                end else if (in_xfer_s) begin
                    if (SKID_EN != 0) begin
                        state_d     = ST_TWO;
                        load_skid_s = 1'b1;
                    end else begin
                        load_out_in_s = 1'b1;
                    end
                end else if (out_xfer_s) begin
                    state_d     = ST_EMPTY;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_xfer_s) begin
                    state_d         = ST_ONE;
                    load_out_skid_s = 1'b1;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    // Payload next-state for the output and skid registers.
    always_comb begin
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        if (load_out_in_s) begin
            out_instr_d = instr_i;
            out_pc_d    = pc_i;
            out_imm_d   = dec_imm_s;
            out_fmt_d   = dec_fmt_s;
            out_ill_d   = dec_ill_s;
        end else if (load_out_skid_s) begin
            out_instr_d = skid_instr_q;
            out_pc_d    = skid_pc_q;
            out_imm_d   = skid_imm_q;
            out_fmt_d   = skid_fmt_q;
            out_ill_d   = skid_ill_q;
        end else begin
            out_instr_d = out_instr_q;
        end
        if (load_skid_s) begin
            skid_instr_d = instr_i;
            skid_pc_d    = pc_i;
            skid_imm_d   = dec_imm_s;
            skid_fmt_d   = dec_fmt_s;
            skid_ill_d   = dec_ill_s;
        end else begin
            skid_instr_d = skid_instr_q;
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            out_instr_q  <= 32'd0;
            out_pc_q     <= {XLEN{1'b0}};
            out_imm_q    <= {XLEN{1'b0}};
            out_fmt_q    <= IMM_NONE;
            out_ill_q    <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= {XLEN{1'b0}};
            skid_imm_q   <= {XLEN{1'b0}};
            skid_fmt_q   <= IMM_NONE;
            skid_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_instr_o   = out_instr_q;
    assign out_pc_o      = out_pc_q;
    assign imm_o         = out_imm_q;
    assign imm_fmt_o     = out_fmt_q;
    assign imm_illegal_o = out_ill_q;

endmodule
